// File: rtl/key_match_stream_18.sv
// -----------------------------------------------------------------------------
// key_match_stream_18
//   Streaming key matcher feeding eq_18. Each accepted key is compared with a
//   programmable reference key. Valid and payload are delayed to line up with
//   eq_18's two-tick result, and the {payload, hit} pair is absorbed into a
//   show-ahead skid FIFO. Credit-based din_ready guarantees the FIFO always has
//   room, so eq_18 (which has no enable) is never stalled.
//
//   Optional feature macro: KEY_MATCH_HIT_CNT_EN (adds hit_count / cnt_clr).
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   ref_key        reference key value, captured on ref_load
//   ref_load       load ref_key into the internal reference register
//   din            key to compare
//   din_payload    payload travelling with din
//   din_valid      input word valid
//   din_ready      block can accept a word this cycle
//   dout_payload   payload of the FIFO head entry
//   dout_hit       head entry's key equalled the reference
//   dout_valid     head entry valid
//   dout_ready     downstream accepts the head entry
//   hit_count      saturating count of dequeued hits (macro only)
//   cnt_clr        synchronous clear of hit_count (macro only)
// -----------------------------------------------------------------------------
module key_match_stream_18 #(
    parameter int          TARGET_CHIP = 2,
    parameter int unsigned PAY_W       = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [17:0]      ref_key,
    input  logic             ref_load,
    input  logic [17:0]      din,
    input  logic [PAY_W-1:0] din_payload,
    input  logic             din_valid,
    output logic             din_ready,
`ifdef KEY_MATCH_HIT_CNT_EN
    output logic [15:0]      hit_count,
    input  logic             cnt_clr,
`endif
    output logic [PAY_W-1:0] dout_payload,
    output logic             dout_hit,
    output logic             dout_valid,
    input  logic             dout_ready
);

    localparam int unsigned KEY_W = 18;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned USE_W = CNT_W + 1;

    // Reference key register
    logic [KEY_W-1:0] ref_key_q, ref_key_d;

    // Alignment pipeline: valid and payload shadows of eq_18's two stages
    logic             p1_q, p1_d, p2_q, p2_d;
    logic [PAY_W-1:0] pay1_q, pay1_d, pay2_q, pay2_d;

    // FIFO control
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             out_en_q;

    // FIFO storage (no reset; reads are gated by dout_valid)
    logic [PAY_W-1:0] mem_pay [FIFO_DEPTH];
    logic             mem_hit [FIFO_DEPTH];

    logic             match;
    logic             acc_c;
    logic             wr_en_c;
    logic             rd_en_c;
    logic [USE_W-1:0] used_c;

    eq_18 #(
        .TARGET_CHIP (TARGET_CHIP)
    ) u_eq (
        .clk   (clk),
        .din_a (din),
        .din_b (ref_key_q),
        .match (match)
    );

    // Handshakes and credit. Occupancy counts queued plus in-flight words; a
    // dequeue in the same cycle is deliberately not credited back.
    always_comb begin
        used_c    = USE_W'(count_q) + USE_W'(p1_q) + USE_W'(p2_q);
        din_ready = out_en_q & (used_c < USE_W'(FIFO_DEPTH));
        acc_c     = din_valid & din_ready;
        wr_en_c   = p2_q;
        dout_valid = (count_q != '0);
        rd_en_c   = dout_valid & dout_ready;
    end

    // Show-ahead head; zero while empty so reset values are deterministic
    always_comb begin
        dout_payload = '0;
        dout_hit     = 1'b0;
        if (dout_valid) begin
            dout_payload = mem_pay[rd_ptr_q];
            dout_hit     = mem_hit[rd_ptr_q];
        end
    end

    // Next-state for reference, pipeline and FIFO control
    always_comb begin
        ref_key_d = ref_key_q;
        p1_d      = acc_c;
        pay1_d    = din_payload;
        p2_d      = p1_q;
        pay2_d    = pay1_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        if (ref_load) begin
            ref_key_d = ref_key;
        end
        // Depth is a power of two, so pointer overflow is the modulo wrap
        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_en_c, rd_en_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_key_q <= '0;
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
            pay1_q    <= '0;
            pay2_q    <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_en_q  <= 1'b0;
        end else begin
            ref_key_q <= ref_key_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            pay1_q    <= pay1_d;
            pay2_q    <= pay2_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_en_q  <= 1'b1;
        end
    end

    // FIFO write: match now belongs to the word tracked by p2
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_pay[wr_ptr_q] <= pay2_q;
            mem_hit[wr_ptr_q] <= match;
        end
    end

`ifdef KEY_MATCH_HIT_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;

    // Saturating hit counter; clear wins over a same-cycle increment
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d = '0;
        end else if (rd_en_c && dout_hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_count = hit_cnt_q;
`endif

endmodule

// -----------------------------------------------------------------------------
// eq_18
//   Two-tick 18-bit equality comparator, no enable, no reset. Stage one
//   registers per-chunk equality, stage two reduces to the match flag.
// Ports
//   clk           clock
//   din_a, din_b  operands
//   match         din_a == din_b, two edges after sampling
// -----------------------------------------------------------------------------
module eq_18 #(
    parameter int TARGET_CHIP = 2
) (
    input  logic        clk,
    input  logic [17:0] din_a,
    input  logic [17:0] din_b,
    output logic        match
);

    // Chunk size tuned to the target's LUT width
    localparam int unsigned CHUNK_W = (TARGET_CHIP == 2) ? 6 : 3;
    localparam int unsigned N_CHUNK = 18 / CHUNK_W;

    logic [N_CHUNK-1:0] chunk_eq_d, chunk_eq_q;

    always_comb begin
        chunk_eq_d = '0;
        for (int unsigned i = 0; i < N_CHUNK; i++) begin
            chunk_eq_d[i] = (din_a[i*CHUNK_W +: CHUNK_W] == din_b[i*CHUNK_W +: CHUNK_W]);
        end
    end

    always_ff @(posedge clk) begin
        chunk_eq_q <= chunk_eq_d;
        match      <= &chunk_eq_q;
    end

endmodule

// File: tb/tb_key_match_stream_18.sv
module tb_key_match_stream_18;

    logic        clk;
    logic        rst_n;
    logic [17:0] ref_key;
    logic        ref_load;
    logic [17:0] din;
    logic [31:0] din_payload;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] dout_payload;
    logic        dout_hit;
    logic        dout_valid;
    logic        dout_ready;
`ifdef KEY_MATCH_HIT_CNT_EN
    logic [15:0] hit_count;
    logic        cnt_clr;
`endif

    key_match_stream_18 #(
        .TARGET_CHIP (2),
        .PAY_W       (32),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ref_key      (ref_key),
        .ref_load     (ref_load),
        .din          (din),
        .din_payload  (din_payload),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
`ifdef KEY_MATCH_HIT_CNT_EN
        .hit_count    (hit_count),
        .cnt_clr      (cnt_clr),
`endif
        .dout_payload (dout_payload),
        .dout_hit     (dout_hit),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: ordered queue of outstanding words, each tagged with
    // the edge at which it was accepted.
    typedef struct {
        logic [31:0] pay;
        logic        hit;
        int          t;
    } sb_t;
    typedef struct {
        logic [31:0] pay;
        logic        hit;
    } out_t;
    typedef struct {
        logic [17:0] key;
        logic [31:0] pay;
        logic        exp_hit;
    } vec_t;

    sb_t         sb[$];
    out_t        log_q[$];
    int          cyc;
    int          outst;
    int          n_acc;
    logic [17:0] ref_m;
    int          checks;
    int          errors;
    logic        clr_v;
    int          hc_m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        outst = 0;
        ref_m = '0;
        hc_m  = 0;
    endtask

    // One clock cycle: drive at negedge, check, update model, advance.
    task automatic cycle(input logic v, input logic [17:0] k, input logic [31:0] p,
                         input logic r, input logic ld, input logic [17:0] rk);
        bit   exp_rdy;
        bit   exp_vld;
        sb_t  e;
        out_t o;
        ref_key     = rk;
        ref_load    = ld;
        din         = k;
        din_payload = p;
        din_valid   = v;
        dout_ready  = r;
`ifdef KEY_MATCH_HIT_CNT_EN
        cnt_clr     = clr_v;
`endif
        #1;
        exp_rdy = (outst < 4);
        exp_vld = (sb.size() != 0) && (sb[0].t + 2 <= cyc);
        chk("din_ready", 64'(din_ready), 64'(exp_rdy));
        chk("dout_valid", 64'(dout_valid), 64'(exp_vld));
`ifdef KEY_MATCH_HIT_CNT_EN
        chk("hit_count", 64'(hit_count), 64'(hc_m));
`endif
        if (dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("dout_payload", 64'(dout_payload), 64'(e.pay));
                chk("dout_hit", 64'(dout_hit), 64'(e.hit));
                o.pay = dout_payload;
                o.hit = dout_hit;
                log_q.push_back(o);
                outst--;
`ifdef KEY_MATCH_HIT_CNT_EN
                if (!clr_v && e.hit && hc_m < 65535) hc_m++;
`endif
            end
        end
`ifdef KEY_MATCH_HIT_CNT_EN
        if (clr_v) hc_m = 0;
`endif
        if (v && din_ready) begin
            e.pay = p;
            e.hit = (k == ref_m);
            e.t   = cyc + 1;
            sb.push_back(e);
            outst++;
            n_acc++;
        end
        if (ld) ref_m = rk;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        ref_load   = 1'b0;
        dout_ready = 1'b0;
        #1;
        chk("rst_dout_valid", 64'(dout_valid), 64'(0));
        chk("rst_din_ready", 64'(din_ready), 64'(0));
        chk("rst_dout_payload", 64'(dout_payload), 64'(0));
        chk("rst_dout_hit", 64'(dout_hit), 64'(0));
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("post_rst_din_ready", 64'(din_ready), 64'(1));
    endtask

    initial begin
        vec_t        tbl[8];
        logic [17:0] k;
        int          guard;

        checks = 0; errors = 0; cyc = 0; n_acc = 0; clr_v = 1'b0;
        rst_n = 1'b0; ref_key = '0; ref_load = 1'b0; din = '0;
        din_payload = '0; din_valid = 1'b0; dout_ready = 1'b0;
`ifdef KEY_MATCH_HIT_CNT_EN
        cnt_clr = 1'b0;
`endif
        model_clear();
        @(negedge clk);
        do_reset();
`ifdef KEY_MATCH_HIT_CNT_EN
        chk("rst_hit_count", 64'(hit_count), 64'(0));
`endif

        // Test 1: alternating hit/miss stream at full throughput
        for (int i = 0; i < 8; i++) begin
            tbl[i].key     = (i % 2 == 0) ? 18'h2A5A5 : 18'h2A5A4;
            tbl[i].pay     = 32'hA000_0000 + 32'(i);
            tbl[i].exp_hit = (i % 2 == 0);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 18'h2A5A5);
        log_q.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, tbl[i].key, tbl[i].pay, 1'b1, 1'b0, '0);
        drain(6);
        chk("t1_count", 64'(log_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            chk("t1_pay", 64'(log_q[i].pay), 64'(tbl[i].pay));
            chk("t1_hit", 64'(log_q[i].hit), 64'(tbl[i].exp_hit));
        end

        // Test 2: backpressure fills exactly FIFO_DEPTH words
        log_q.delete();
        n_acc = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 18'h2A5A5, 32'hB000_0000 + 32'(n_acc), 1'b0, 1'b0, '0);
        chk("t2_accepted", 64'(n_acc), 64'(4));
        chk("t2_ready_low", 64'(din_ready), 64'(0));
        drain(8);
        chk("t2_out_count", 64'(log_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            chk("t2_order", 64'(log_q[i].pay), 64'(32'hB000_0000 + 32'(i)));

        // Test 4: reset with two queued and two in flight
        for (int i = 0; i < 4; i++) cycle(1'b1, 18'h11111, 32'hC000_0000 + 32'(i), 1'b0, 1'b0, '0);
        do_reset();

        // Test 3: ref_load on the same edge as an accept uses the old value
        log_q.delete();
        cycle(1'b1, 18'h00001, 32'hD000_0000, 1'b1, 1'b1, 18'h00001);
        cycle(1'b1, 18'h00001, 32'hD000_0001, 1'b1, 1'b0, '0);
        drain(5);
        chk("t3_count", 64'(log_q.size()), 64'(2));
        if (log_q.size() == 2) begin
            chk("t3_old_ref_hit", 64'(log_q[0].hit), 64'(0));
            chk("t3_new_ref_hit", 64'(log_q[1].hit), 64'(1));
        end

`ifdef KEY_MATCH_HIT_CNT_EN
        // Test 5: hit counter, clear priority, saturation
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, '0, 32'(i), 1'b1, 1'b0, '0);
        drain(6);
        chk("t5_five_hits", 64'(hit_count), 64'(5));
        cycle(1'b1, '0, 32'h55, 1'b0, 1'b0, '0);
        drain(0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);
        clr_v = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        clr_v = 1'b0;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        chk("t5_clr_wins", 64'(hit_count), 64'(0));
        for (int i = 0; i < 65534; i++) cycle(1'b1, '0, 32'(i), 1'b1, 1'b0, '0);
        drain(6);
        chk("t5_fffe", 64'(hit_count), 64'(16'hFFFE));
        for (int i = 0; i < 3; i++) cycle(1'b1, '0, 32'(i), 1'b1, 1'b0, '0);
        drain(6);
        chk("t5_saturate", 64'(hit_count), 64'(16'hFFFF));
`endif

        // Test 6: random traffic against the scoreboard
        n_acc = 0;
        guard = 0;
        while (n_acc < 10000 && guard < 60000) begin
            logic        v, r, ld;
            logic [17:0] rk;
            case ($urandom_range(2))
                0:       k = ref_m;
                1:       k = ref_m ^ (18'h1 << $urandom_range(17));
                default: k = 18'($urandom);
            endcase
            v  = ($urandom_range(9) < 7);
            r  = ($urandom_range(9) < 7);
            ld = ($urandom_range(49) == 0);
            rk = ($urandom_range(1) == 0) ? 18'($urandom) : k;
            cycle(v, k, $urandom, r, ld, rk);
            guard++;
        end
        chk("t6_budget", 64'(n_acc >= 10000), 64'(1));
        drain(10);
        chk("t6_no_drops", 64'(sb.size()), 64'(0));
        chk("t6_idle_valid", 64'(dout_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
